// File: rtl/hsid_word_unpacker.sv
// Unpacks 32-bit HSI pixel words into a stream of masked 16-bit band samples,
// one per cycle, flagging the final band and pulsing done at pixel end.
module hsid_word_unpacker #(
   parameter int WORD_WIDTH  = 32,
   parameter int DATA_WIDTH  = 16,
   parameter int PIXEL_WIDTH = 14,
   parameter int LENGTH_BITS = 10
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [LENGTH_BITS-1:0] hsi_bands,
   input  logic                   word_valid,
   output logic                   word_ready,
   input  logic [WORD_WIDTH-1:0]  word_data,
   output logic                   band_valid,
   input  logic                   band_ready,
   output logic [DATA_WIDTH-1:0]  band_data,
   output logic                   band_last,
   output logic                   busy,
   output logic                   done
);

   // loaded counts samples brought in by accepted words; one extra bit so an
   // odd max band count (1023 -> 1024 loaded) cannot wrap
   localparam int CW = LENGTH_BITS + 1;
   localparam logic [LENGTH_BITS-1:0] ONE = {{(LENGTH_BITS-1){1'b0}}, 1'b1};
   localparam logic [DATA_WIDTH-1:0] PIX_MASK =
      {{(DATA_WIDTH-PIXEL_WIDTH){1'b0}}, {PIXEL_WIDTH{1'b1}}};

   typedef enum logic [1:0] {ST_IDLE, ST_UNPACK, ST_DONE} state_t;

   state_t state, state_n;

   logic [LENGTH_BITS-1:0] bands_q;
   logic [LENGTH_BITS-1:0] count;
   logic [CW-1:0]          loaded;
   logic [DATA_WIDTH-1:0]  hi_data;
   logic                   hi_pend;
   logic                   fire, need_more, accept;

   assign fire       = band_valid && band_ready;
   assign band_last  = band_valid && (count == bands_q - ONE);
   assign need_more  = loaded < {1'b0, bands_q};
   // A new word may land when the output is free or its last useful half is
   // leaving this cycle, which keeps the stream at one sample per cycle.
   assign word_ready = (state == ST_UNPACK) && need_more &&
                       (!band_valid || (fire && !hi_pend));
   assign accept     = word_valid && word_ready;
   assign busy       = (state == ST_UNPACK);
   assign done       = (state == ST_DONE);

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         ST_IDLE:   if (start) state_n = (hsi_bands == '0) ? ST_DONE : ST_UNPACK;
         ST_UNPACK: if (fire && band_last) state_n = ST_DONE;
         ST_DONE:   state_n = ST_IDLE;
         default:   state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bands_q    <= '0;
         count      <= '0;
         loaded     <= '0;
         hi_data    <= '0;
         hi_pend    <= 1'b0;
         band_valid <= 1'b0;
         band_data  <= '0;
      end else if (state == ST_IDLE && start) begin
         bands_q    <= hsi_bands;
         count      <= '0;
         loaded     <= '0;
         hi_pend    <= 1'b0;
         band_valid <= 1'b0;
      end else begin
         if (fire) count <= count + ONE;
         if (accept) begin
            // low half goes straight out; high half is kept only if needed
            band_data  <= word_data[DATA_WIDTH-1:0] & PIX_MASK;
            band_valid <= 1'b1;
            hi_data    <= word_data[2*DATA_WIDTH-1:DATA_WIDTH] & PIX_MASK;
            hi_pend    <= (loaded + CW'(1)) < {1'b0, bands_q};
            loaded     <= loaded + CW'(2);
         end else if (fire) begin
            if (hi_pend) begin
               band_data <= hi_data;
               hi_pend   <= 1'b0;
            end else begin
               band_valid <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_hsid_word_unpacker.sv
// Randomized scoreboard bench for hsid_word_unpacker: expected samples are
// derived from the word list per pixel and popped by an output monitor.
module tb_hsid_word_unpacker;

   logic        clk = 1'b0;
   logic        rst, start, word_valid, word_ready, band_valid, band_ready;
   logic        band_last, busy, done;
   logic [9:0]  hsi_bands;
   logic [31:0] word_data;
   logic [15:0] band_data;

   hsid_word_unpacker dut (
      .clk(clk), .rst(rst), .start(start), .hsi_bands(hsi_bands),
      .word_valid(word_valid), .word_ready(word_ready), .word_data(word_data),
      .band_valid(band_valid), .band_ready(band_ready), .band_data(band_data),
      .band_last(band_last), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct { logic [15:0] data; logic last; } exp_t;

   exp_t        exp_q[$];
   logic [31:0] words[$];
   int          checks = 0, passed = 0, pops = 0;
   int          done_cyc, acc, dcnt;
   bit          saw_bv, saw_wr, aborted;
   bit          stall_q = 0;
   logic [15:0] stall_d;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // output monitor: pops expected samples on every handshake
   always @(negedge clk) begin
      if (rst) begin
         stall_q = 0;
      end else begin
         if (stall_q) begin
            chk("stall_valid", band_valid, 1);
            chk("stall_data", band_data, stall_d);
         end
         if (band_valid && band_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               $display("FAIL extra_sample: got %0h expected no sample", band_data);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("band_data", band_data, e.data);
               chk("band_last", band_last, e.last);
               pops++;
            end
         end
         stall_q = band_valid && !band_ready;
         stall_d = band_data;
      end
   end

   task automatic run_pixel(int n, int rdy_mode, int val_mode, int abort);
      int idx = 0;
      for (int i = 0; i < n; i++) begin
         exp_t e;
         logic [31:0] w;
         w = words[i/2];
         e.data = ((i % 2) ? w[31:16] : w[15:0]) & 16'h3FFF;
         e.last = (i == n - 1);
         exp_q.push_back(e);
      end
      pops = 0; acc = 0; dcnt = 0; done_cyc = -1;
      saw_bv = 0; saw_wr = 0; aborted = 0;
      @(posedge clk); #1;
      start = 1; hsi_bands = 10'(n);
      @(posedge clk); #1;
      start = 0; hsi_bands = 10'($urandom);
      for (int cyc = 0; cyc < 4 * n + 40; cyc++) begin
         if (abort > 0 && pops >= abort) begin
            rst = 1;
            @(posedge clk); #1;
            rst = 0;
            exp_q.delete();
            aborted = 1;
            break;
         end
         if (rdy_mode == 0)      band_ready = 1'b1;
         else if (rdy_mode == 1) band_ready = (cyc % 2 == 0);
         else                    band_ready = 1'($urandom % 2);
         word_valid = (idx < words.size()) && (val_mode == 0 || ($urandom % 3) != 0);
         word_data  = (idx < words.size()) ? words[idx] : $urandom;
         @(negedge clk);
         if (band_valid) saw_bv = 1;
         if (word_ready) saw_wr = 1;
         if (word_valid && word_ready) begin acc++; idx++; end
         if (done) begin
            dcnt++;
            if (done_cyc < 0) begin
               done_cyc = cyc;
               chk("busy_at_done", busy, 0);
            end
         end
         if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
         @(posedge clk); #1;
      end
      band_ready = 0; word_valid = 0;
      if (!aborted) begin
         chk("done_seen", (done_cyc >= 0), 1);
         chk("done_pulses", dcnt, 1);
         chk("words_accepted", acc, (n + 1) / 2);
         chk("queue_drained", exp_q.size(), 0);
      end
   endtask

   initial begin
      rst = 1; start = 0; hsi_bands = 0; word_valid = 0; word_data = 0; band_ready = 0;
      repeat (3) @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      chk("rst_word_ready", word_ready, 0);
      chk("rst_band_valid", band_valid, 0);
      chk("rst_band_last", band_last, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_band_data", band_data, 0);

      // sequential samples 1..32, full rate
      words.delete();
      for (int i = 0; i < 18; i++) words.push_back({16'(2*i+2), 16'(2*i+1)});
      run_pixel(32, 0, 0, 0);
      chk("t1_latency", done_cyc, 33);

      // odd count, upper half of last word dropped, surplus words untouched
      words = '{32'h0002_0001, 32'h0004_0003, 32'hBEEF_0005, 32'h1234_5678, 32'h9ABC_DEF0};
      run_pixel(5, 0, 0, 0);

      // masking of the bits above the pixel width
      words = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      run_pixel(3, 0, 0, 0);

      // random lengths, stalls and gaps
      for (int p = 0; p < 6; p++) begin
         int n;
         n = $urandom_range(1, 60);
         words.delete();
         for (int i = 0; i < (n + 1) / 2 + $urandom_range(0, 3); i++) words.push_back($urandom);
         run_pixel(n, (p < 3) ? 1 : 2, 1, 0);
      end

      // zero-length pixel
      words = '{32'hDEAD_BEEF, 32'hCAFE_F00D};
      run_pixel(0, 0, 0, 0);
      chk("t5_done_next", done_cyc, 0);
      chk("t5_no_band_valid", saw_bv, 0);
      chk("t5_no_word_ready", saw_wr, 0);

      // reset mid-pixel, then a fresh short pixel
      words.delete();
      for (int i = 0; i < 16; i++) words.push_back($urandom);
      run_pixel(32, 0, 0, 7);
      chk("t6_aborted", aborted, 1);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("t6_no_done", done, 0);
         chk("t6_idle_valid", band_valid, 0);
         chk("t6_idle_busy", busy, 0);
      end
      words = '{32'h1111_2222, 32'h3333_4444, 32'h5555_6666};
      run_pixel(4, 0, 0, 0);

      // single band and maximum band count
      words = '{32'hABCD_1234, 32'h0000_0001};
      run_pixel(1, 0, 0, 0);
      chk("n1_latency", done_cyc, 2);
      words.delete();
      for (int i = 0; i < 514; i++) words.push_back($urandom);
      run_pixel(1023, 0, 0, 0);
      chk("max_latency", done_cyc, 1024);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
